// File: rtl/mux_2x1_8bits_if.sv
// Lane-side and link-side signal bundle for the 2:1 lane merger.
// master: lane sources + downstream sink; slave: the merger itself.
interface mux_2x1_8bits_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in0;
  logic             valid_in0;
  logic [WIDTH-1:0] data_in1;
  logic             valid_in1;
  logic             ready_in;
  logic             full0;
  logic             full1;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             lane_out;
  logic             overflow;

  modport master (
    output data_in0,
    output valid_in0,
    output data_in1,
    output valid_in1,
    output ready_in,
    input  full0,
    input  full1,
    input  data_out,
    input  valid_out,
    input  lane_out,
    input  overflow
  );

  modport slave (
    input  data_in0,
    input  valid_in0,
    input  data_in1,
    input  valid_in1,
    input  ready_in,
    output full0,
    output full1,
    output data_out,
    output valid_out,
    output lane_out,
    output overflow
  );
endinterface

// File: rtl/mux_2x1_8bits.sv
// Merges two valid-qualified lanes through per-lane FIFOs and a
// round-robin arbiter into one registered, lane-tagged stream.
//   clk, reset      : clock, async active-high reset
//   bus.data_inN    : lane N data, pushed when bus.valid_inN=1
//   bus.ready_in    : downstream accepts data_out
//   bus.fullN       : lane N FIFO holds DEPTH entries
//   bus.data_out/valid_out/lane_out : registered merged output
//   bus.overflow    : sticky, a push hit a full lane and was lost
module mux_2x1_8bits #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  mux_2x1_8bits_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem    [2][DEPTH];
  logic [AW-1:0]    wr_ptr [2];
  logic [AW-1:0]    rd_ptr [2];
  logic [AW:0]      cnt    [2];
  logic [WIDTH-1:0] din    [2];

  logic [1:0] vin;
  logic [1:0] ne;
  logic [1:0] full;
  logic [1:0] pop;
  logic [1:0] push;
  logic [1:0] drop;
  logic       adv;
  logic       win;
  logic       last;

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             lane_q;
  logic             ovf_q;

  assign din[0] = bus.data_in0;
  assign din[1] = bus.data_in1;
  assign vin    = {bus.valid_in1, bus.valid_in0};

  always_comb begin
    ne   = '0;
    full = '0;
    pop  = '0;
    adv  = ~valid_q | bus.ready_in;
    for (int i = 0; i < 2; i++) begin
      ne[i]   = (cnt[i] != '0);
      full[i] = (cnt[i] == FULL);
    end
    // lane 1 wins if it is the only candidate, or both
    // are pending and lane 0 was served last
    win = ne[1] & (~ne[0] | ~last);
    if (adv && (|ne)) begin
      pop[win] = 1'b1;
    end
    // a full lane still accepts a push when it pops
    // in the same cycle (its head slot is freed)
    push = vin & (~full | pop);
    drop = vin & full & ~pop;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= din[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
        cnt[i] <= cnt[i]
                + {{AW{1'b0}}, push[i]}
                - {{AW{1'b0}}, pop[i]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      lane_q  <= 1'b0;
      ovf_q   <= 1'b0;
      last    <= 1'b1;
    end else begin
      if (|drop) begin
        ovf_q <= 1'b1;
      end
      if (adv) begin
        if (|ne) begin
          data_q  <= mem[win][rd_ptr[win]];
          lane_q  <= win;
          valid_q <= 1'b1;
          last    <= win;
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.full0     = full[0];
  assign bus.full1     = full[1];
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.lane_out  = lane_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_mux_2x1_8bits.sv
// Scoreboard bench for the 2:1 lane merger.
// Per-lane expected queues plus an optional lane-order queue.
module tb_mux_2x1_8bits;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic       lq [$];

  mux_2x1_8bits_if #(.WIDTH(8)) bus ();

  mux_2x1_8bits #(
    .WIDTH(8),
    .DEPTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // a word transfers at the next rising edge when
  // valid_out & ready_in are both high at the falling edge
  always @(negedge clk) begin
    if (!reset && bus.valid_out && bus.ready_in) begin
      if (bus.lane_out) begin
        if (q1.size() == 0)
          chk("l1_unexpected", 32'(q1.size()), 1);
        else
          chk("l1_data", bus.data_out, q1.pop_front());
      end else begin
        if (q0.size() == 0)
          chk("l0_unexpected", 32'(q0.size()), 1);
        else
          chk("l0_data", bus.data_out, q0.pop_front());
      end
      if (lq.size() != 0)
        chk("lane_order", bus.lane_out, lq.pop_front());
    end
  end

  task automatic push(input bit v0, input logic [7:0] d0,
                      input bit v1, input logic [7:0] d1,
                      input bit keep);
    bus.valid_in0 = v0;
    bus.data_in0  = d0;
    bus.valid_in1 = v1;
    bus.data_in1  = d1;
    if (keep) begin
      if (v0) q0.push_back(d0);
      if (v1) q1.push_back(d1);
    end
    @(posedge clk);
    #1;
    bus.valid_in0 = 1'b0;
    bus.valid_in1 = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int i = 0;
    while ((q0.size() + q1.size()) != 0 && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk(tag, 32'(q0.size() + q1.size()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.ready_in  = 1'b0;
    bus.valid_in0 = 1'b0;
    bus.valid_in1 = 1'b0;
    bus.data_in0  = '0;
    bus.data_in1  = '0;
    #2;
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_lane", bus.lane_out, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_full0", bus.full0, 0);
    chk("rst_full1", bus.full1, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // alternation from reset: lane 0 wins first
    bus.ready_in = 1'b1;
    lq.push_back(1'b0);
    lq.push_back(1'b1);
    lq.push_back(1'b0);
    lq.push_back(1'b1);
    push(1, 8'h10, 1, 8'h20, 1);
    push(1, 8'h11, 1, 8'h21, 1);
    drain("t3_drain", 20);

    // single lane, latency of one edge
    repeat (3) lq.push_back(1'b0);
    push(1, 8'hA1, 0, 8'h00, 1);
    chk("t2_lat_valid", bus.valid_out, 0);
    push(1, 8'hA2, 0, 8'h00, 1);
    chk("t2_first_valid", bus.valid_out, 1);
    chk("t2_first_data", bus.data_out, 8'hA1);
    push(1, 8'hA3, 0, 8'h00, 1);
    chk("t2_second_data", bus.data_out, 8'hA2);
    drain("t2_drain", 20);

    // backpressure hold
    bus.ready_in = 1'b0;
    push(1, 8'h55, 0, 8'h00, 1);
    push(1, 8'h56, 0, 8'h00, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("t4_hold_data", bus.data_out, 8'h55);
      chk("t4_hold_valid", bus.valid_out, 1);
    end
    bus.ready_in = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_next_data", bus.data_out, 8'h56);
    drain("t4_drain", 20);

    // full / overflow on lane 1, output reg occupied
    bus.ready_in = 1'b0;
    lq.push_back(1'b0);
    repeat (4) lq.push_back(1'b1);
    push(1, 8'h77, 0, 8'h00, 1);
    push(0, 8'h00, 1, 8'h01, 1);
    push(0, 8'h00, 1, 8'h02, 1);
    push(0, 8'h00, 1, 8'h03, 1);
    chk("t5_full1_early", bus.full1, 0);
    push(0, 8'h00, 1, 8'h04, 1);
    chk("t5_full1", bus.full1, 1);
    chk("t5_ovf_early", bus.overflow, 0);
    push(0, 8'h00, 1, 8'h05, 0);
    chk("t5_ovf", bus.overflow, 1);
    chk("t5_full1_kept", bus.full1, 1);
    bus.ready_in = 1'b1;
    drain("t5_drain", 20);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_full1_clear", bus.full1, 0);
    chk("t5_ovf_sticky", bus.overflow, 1);
    chk("t5_idle", bus.valid_out, 0);

    // async reset with data buffered
    bus.ready_in = 1'b0;
    push(1, 8'h91, 0, 8'h00, 0);
    push(1, 8'h92, 0, 8'h00, 0);
    push(0, 8'h00, 1, 8'h93, 0);
    chk("t1_pre_valid", bus.valid_out, 1);
    chk("t1_pre_data", bus.data_out, 8'h91);
    #2;
    reset = 1'b1;
    #1;
    chk("t1_valid", bus.valid_out, 0);
    chk("t1_data", bus.data_out, 0);
    chk("t1_ovf", bus.overflow, 0);
    chk("t1_full0", bus.full0, 0);
    chk("t1_full1", bus.full1, 0);
    q0.delete();
    q1.delete();
    lq.delete();
    #10;
    reset = 1'b0;
    bus.ready_in = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("t1_no_valid", bus.valid_out, 0);
    end

    // streaming with pointer wrap on both lanes
    for (int i = 0; i < 12; i++) begin
      lq.push_back(1'b0);
      lq.push_back(1'b1);
      push(1, 8'(8'h40 + i), 1, 8'(8'hC0 + i), 1);
      push(0, 8'h00, 0, 8'h00, 0);
    end
    drain("t6_drain", 40);
    chk("t6_ovf", bus.overflow, 0);
    chk("lane_order_left", 32'(lq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
